hilo_muldiv_ctrl: RTL

Multi-cycle multiply/divide sequencer that owns all writes into the HI/LO register pair. Sits in EX beside the ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the issuing instruction. It runs a 32-iteration shift-add multiply or restoring divide and stalls the pipeline until the result is ready. It then drives the HI/LO write port (we, w_hi_i, w_lo_i) for exactly one cycle.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 21 ++
 rtl/hilo_muldiv_ctrl_muldiv_iter.sv | 68 ++++++
 rtl/hilo_muldiv_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared op codes and iterator mode for the HI/LO sequencer
package hilo_muldiv_ctrl_pkg;

    localparam logic [2:0] HL_MULT  = 3'd0;
    localparam logic [2:0] HL_MULTU = 3'd1;
    localparam logic [2:0] HL_DIV   = 3'd2;
    localparam logic [2:0] HL_DIVU  = 3'd3;
    localparam logic [2:0] HL_MTHI  = 3'd4;
    localparam logic [2:0] HL_MTLO  = 3'd5;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

    // Ops that need the iterative datapath (and therefore stall EX)
    function automatic logic is_muldiv_op(input logic [2:0] op);
        return (op == HL_MULT) || (op == HL_MULTU) || (op == HL_DIV) || (op == HL_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_muldiv_iter.sv
// rtl/hilo_muldiv_ctrl_muldiv_iter.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath
//   clk, rst       clock, async active-low reset
//   start          load a_mag into the low half / quotient, b_mag as multiplicand / divisor
//   step           advance one iteration in the given mode
//   mode           MODE_MUL or MODE_DIV
//   nxt_hi/nxt_lo  magnitude result after the current step (product hi/lo or remainder/quotient)
module muldiv_iter
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  iter_mode_e        mode,
    input  logic [DATA_W-1:0] a_mag,
    input  logic [DATA_W-1:0] b_mag,
    output logic [DATA_W-1:0] nxt_hi,
    output logic [DATA_W-1:0] nxt_lo
);

    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [DATA_W-1:0] opnd;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W+1:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        nxt_hi    = acc_hi;
        nxt_lo    = acc_lo;
        if (mode == MODE_MUL) begin
            // Multiplier bits are consumed from acc_lo[0]; product shifts in from the top
            nxt_hi = mul_sum[DATA_W:1];
            nxt_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
        end else begin
            // Dividend bits leave acc_lo from the top while quotient bits enter at the bottom
            if (!div_diff[DATA_W+1]) begin
                nxt_hi = div_diff[DATA_W-1:0];
                nxt_lo = {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[DATA_W-1:0];
                nxt_lo = {acc_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else if (start) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            opnd   <= b_mag;
        end else if (step) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO write sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   clk, rst             clock, async active-low reset
//   op_valid, op         HI/LO-writing instruction in EX
//   src_a, src_b         rs / rt operands
//   hi_i, lo_i           current HI/LO, used for the half an MT op leaves unchanged
//   flush                kill the EX instruction / in-flight operation
//   stallreq             hold the pipeline while the iteration runs
//   hilo_we, hilo_hi_o, hilo_lo_o   one-cycle HI/LO write port
//   busy                 iteration in progress
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              flush,
    output logic              stallreq,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hilo_hi_o,
    output logic [DATA_W-1:0] hilo_lo_o,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e            state;
    logic [CNT_W-1:0]  counter;
    logic              sign_q;   // quotient / product sign: sign_a ^ sign_b
    logic              sign_r;   // remainder sign: sign of dividend
    logic              we_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              iter_start;
    logic              iter_step;
    iter_mode_e        iter_mode;
    logic [DATA_W-1:0] nxt_hi;
    logic [DATA_W-1:0] nxt_lo;
    logic [2*DATA_W-1:0] prod_raw;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    always_comb begin
        is_signed  = (op == HL_MULT) || (op == HL_DIV);
        a_neg      = is_signed & src_a[DATA_W-1];
        b_neg      = is_signed & src_b[DATA_W-1];
        a_mag      = a_neg ? -src_a : src_a;
        b_mag      = b_neg ? -src_b : src_b;
        iter_start = (state == S_IDLE) && op_valid && !flush &&
                     ((op == HL_MULT) || (op == HL_MULTU) ||
                      (((op == HL_DIV) || (op == HL_DIVU)) && (src_b != '0)));
        iter_step  = ((state == S_MUL) || (state == S_DIV)) && !flush;
        iter_mode  = (state == S_DIV) ? MODE_DIV : MODE_MUL;
        // Sign fix operates on the post-step value so the final iteration lands directly in WB
        prod_raw   = {nxt_hi, nxt_lo};
        prod_fix   = sign_q ? -prod_raw : prod_raw;
        quo_fix    = sign_q ? -nxt_lo : nxt_lo;
        rem_fix    = sign_r ? -nxt_hi : nxt_hi;
    end

    muldiv_iter #(.DATA_W(DATA_W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .step   (iter_step),
        .mode   (iter_mode),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            counter <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            we_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid && !flush) begin
                        case (op)
                            HL_MTHI: begin
                                we_q <= 1'b1;
                                hi_q <= src_a;
                                lo_q <= lo_i;
                            end
                            HL_MTLO: begin
                                we_q <= 1'b1;
                                hi_q <= hi_i;
                                lo_q <= src_a;
                            end
                            HL_MULT, HL_MULTU: begin
                                state   <= S_MUL;
                                counter <= '0;
                                sign_q  <= a_neg ^ b_neg;
                                sign_r  <= a_neg;
                            end
                            HL_DIV, HL_DIVU: begin
                                if (src_b == '0) begin
                                    state <= S_WB;
                                    we_q  <= 1'b1;
                                    hi_q  <= src_a;
                                    lo_q  <= '1;
                                end else begin
                                    state   <= S_DIV;
                                    counter <= '0;
                                    sign_q  <= a_neg ^ b_neg;
                                    sign_r  <= a_neg;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state   <= S_IDLE;
                        counter <= '0;
                    end else if (counter == CNT_W'(DATA_W - 1)) begin
                        state   <= S_WB;
                        counter <= '0;
                        we_q    <= 1'b1;
                        if (state == S_MUL) begin
                            hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                            lo_q <= prod_fix[DATA_W-1:0];
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;   // S_WB: op_valid is the stalled instruction, ignore it
            endcase
        end
    end

    assign stallreq  = ((state == S_IDLE) && op_valid && is_muldiv_op(op)) ||
                       (state == S_MUL) || (state == S_DIV);
    assign hilo_we   = we_q & ~flush;
    assign hilo_hi_o = hi_q;
    assign hilo_lo_o = lo_q;
    assign busy      = (state == S_MUL) || (state == S_DIV);

endmodule
